// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter and sequencer for a shared 4:1 muxed data channel
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   req[3:0]       request per requester, bit i belongs to Di
//   D0..D3         requester data words (WIDTH bits)
//   ready          downstream accepts Out this cycle
//   Out            granted data word, zero while idle
//   valid          Out carries a transferable word
//   gnt[3:0]       registered one-hot grant, zero while idle
//   s1, s0         registered mux select, {s1,s0} is the owner index
//
// Parameters:
//   WIDTH          data width
//   MAX_BURST      accepted transfers per tenure before the grant is released (>= 1)

module mux_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic [WIDTH-1:0] D3,
    input  logic             ready,
    output logic [WIDTH-1:0] Out,
    output logic             valid,
    output logic [3:0]       gnt,
    output logic             s1,
    output logic             s0
);

    // Burst counter is at least one bit wide, even for MAX_BURST of 1 or 2.
    localparam int CNT_W = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       owner;
    logic [1:0]       owner_nxt;
    logic [1:0]       last;
    logic [1:0]       last_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [3:0]       gnt_q;
    logic [3:0]       gnt_nxt;

    logic             xfer;
    logic             release_now;
    logic [2:0]       pick_idle;
    logic [2:0]       pick_handoff;
    logic [WIDTH-1:0] mux_word;

    // Round-robin search starting just after 'base'; 'base' itself is tried
    // last so the previous owner only wins when nobody else is asking.
    // Result is {found, index}. Offsets are scanned from farthest to nearest
    // so the nearest requesting offset is the final assignment.
    function automatic logic [2:0] rr_pick(input logic [1:0] base, input logic [3:0] r);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 4; i >= 1; i--) begin
            idx = base + 2'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Idle search uses the stored previous owner; the handoff search treats
    // the owner being released as the new 'last'.
    assign pick_idle    = rr_pick(last, req);
    assign pick_handoff = rr_pick(owner, req);

    assign xfer        = valid && ready;
    assign release_now = !req[owner] || (xfer && (cnt == CNT_LAST));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= 2'd0;
            last  <= 2'd3;
            cnt   <= '0;
            gnt_q <= 4'b0000;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
            gnt_q <= gnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt_q;
        case (state)
            IDLE: begin
                if (pick_idle[2]) begin
                    state_nxt = GRANT;
                    owner_nxt = pick_idle[1:0];
                    gnt_nxt   = onehot(pick_idle[1:0]);
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    last_nxt = owner;
                    cnt_nxt  = '0;
                    if (pick_handoff[2]) begin
                        // Zero-bubble handoff: new owner is live next cycle.
                        owner_nxt = pick_handoff[1:0];
                        gnt_nxt   = onehot(pick_handoff[1:0]);
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = 4'b0000;
                    end
                end else if (xfer) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
        endcase
    end

    // Output logic: data path follows the registered owner, gated by state.
    always_comb begin
        mux_word = D0;
        case (owner)
            2'd0: mux_word = D0;
            2'd1: mux_word = D1;
            2'd2: mux_word = D2;
            2'd3: mux_word = D3;
        endcase
        Out   = (state == GRANT) ? mux_word : '0;
        valid = (state == GRANT) && req[owner];
    end

    assign gnt = gnt_q;
    assign s1  = owner[1];
    assign s0  = owner[0];

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - self-checking bench for mux_rr_arbiter (MAX_BURST 4 and 1 instances)

module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [7:0] D0, D1, D2, D3;
    logic       ready;

    logic [7:0] out_a, out_b;
    logic       valid_a, valid_b;
    logic [3:0] gnt_a, gnt_b;
    logic       s1_a, s0_a, s1_b, s0_b;

    int errors;
    int checks;

    mux_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut_a (
        .clk(clk), .rst(rst), .req(req),
        .D0(D0), .D1(D1), .D2(D2), .D3(D3),
        .ready(ready), .Out(out_a), .valid(valid_a),
        .gnt(gnt_a), .s1(s1_a), .s0(s0_a)
    );

    mux_rr_arbiter #(.WIDTH(8), .MAX_BURST(1)) dut_b (
        .clk(clk), .rst(rst), .req(req),
        .D0(D0), .D1(D1), .D2(D2), .D3(D3),
        .ready(ready), .Out(out_b), .valid(valid_b),
        .gnt(gnt_b), .s1(s1_b), .s0(s0_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: one entry per instance. busy = somebody holds the
    // channel, done = transfers accepted in the current tenure.
    int m_busy  [2];
    int m_owner [2];
    int m_last  [2];
    int m_done  [2];
    int m_max   [2];

    function automatic int pick(input int base, input logic [3:0] r);
        for (int i = 1; i <= 4; i++) begin
            if (r[(base + i) % 4]) return (base + i) % 4;
        end
        return -1;
    endfunction

    function automatic logic [7:0] word_of(input int i);
        case (i)
            0: return D0;
            1: return D1;
            2: return D2;
            default: return D3;
        endcase
    endfunction

    task automatic model_adv();
        int w;
        bit moved;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_busy[k] = 0; m_owner[k] = 0; m_last[k] = 3; m_done[k] = 0;
            end else if (m_busy[k] == 0) begin
                w = pick(m_last[k], req);
                if (w >= 0) begin
                    m_busy[k] = 1; m_owner[k] = w; m_done[k] = 0;
                end
            end else begin
                moved = req[m_owner[k]] && ready;
                if (!req[m_owner[k]] || (moved && (m_done[k] + 1 == m_max[k]))) begin
                    m_last[k] = m_owner[k];
                    w = pick(m_owner[k], req);
                    if (w >= 0) m_owner[k] = w;
                    else        m_busy[k] = 0;
                    m_done[k] = 0;
                end else begin
                    m_done[k] = m_done[k] + (moved ? 1 : 0);
                end
            end
        end
    endtask

    task automatic tick();
        model_adv();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0000; ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; ready = 1'b1;
        D0 = 8'h11; D1 = 8'h22; D2 = 8'h33; D3 = 8'h44;
        tick();
        #1;
        checks++; if (gnt_a !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt_a); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_a); end
        checks++; if (out_a !== 8'h00) begin errors++; $display("FAIL reset_out: got %h want 00", out_a); end
        checks++; if ({s1_a, s0_a} !== 2'b00) begin errors++; $display("FAIL reset_sel: got %b want 00", {s1_a, s0_a}); end
        checks++; if (gnt_b !== 4'b0000) begin errors++; $display("FAIL reset_gnt_b: got %b want 0000", gnt_b); end
        rst = 1'b0;
        tick();
        #1;
        checks++; if (gnt_a !== 4'b0001) begin errors++; $display("FAIL reset_first_prio: got %b want 0001", gnt_a); end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001; D0 = 8'hA5; ready = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (gnt_a !== 4'b0001) begin errors++; $display("FAIL single_gnt c%0d: got %b want 0001", c, gnt_a); end
            checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL single_valid c%0d: got %b want 1", c, valid_a); end
            checks++; if (out_a !== 8'hA5) begin errors++; $display("FAIL single_out c%0d: got %h want a5", c, out_a); end
            tick();
        end
    endtask

    task automatic test_rotation();
        logic [1:0] es;
        logic [7:0] ed;
        do_reset();
        D0 = 8'h10; D1 = 8'h21; D2 = 8'h32; D3 = 8'h43;
        req = 4'b1111; ready = 1'b1;
        tick();
        for (int c = 0; c < 20; c++) begin
            es = 2'((c / 4) % 4);
            ed = 8'h10 + 8'h11 * 8'(es);
            #1;
            checks++; if ({s1_a, s0_a} !== es) begin errors++; $display("FAIL rot_sel c%0d: got %b want %b", c, {s1_a, s0_a}, es); end
            checks++; if (out_a !== ed) begin errors++; $display("FAIL rot_out c%0d: got %h want %h", c, out_a, ed); end
            checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL rot_valid c%0d: got %b want 1", c, valid_a); end
            tick();
        end
    endtask

    task automatic test_stall();
        do_reset();
        req = 4'b1100; ready = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (gnt_a !== 4'b0100) begin errors++; $display("FAIL stall_gnt c%0d: got %b want 0100", c, gnt_a); end
            checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL stall_valid c%0d: got %b want 1", c, valid_a); end
            tick();
        end
        ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (gnt_a !== 4'b0100) begin errors++; $display("FAIL stall_burst c%0d: got %b want 0100", c, gnt_a); end
            tick();
        end
        #1;
        checks++; if (gnt_a !== 4'b1000) begin errors++; $display("FAIL stall_handoff: got %b want 1000", gnt_a); end
    endtask

    task automatic test_drop();
        do_reset();
        D3 = 8'h3C; req = 4'b1010; ready = 1'b1;
        tick();
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (gnt_a !== 4'b0010) begin errors++; $display("FAIL drop_gnt c%0d: got %b want 0010", c, gnt_a); end
            tick();
        end
        req = 4'b1001;
        #1;
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL drop_valid: got %b want 0", valid_a); end
        tick();
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (gnt_a !== 4'b1000) begin errors++; $display("FAIL drop_new_gnt c%0d: got %b want 1000", c, gnt_a); end
            checks++; if (out_a !== 8'h3C) begin errors++; $display("FAIL drop_out c%0d: got %h want 3c", c, out_a); end
            tick();
        end
        #1;
        checks++; if (gnt_a !== 4'b0001) begin errors++; $display("FAIL drop_next: got %b want 0001", gnt_a); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b1000; ready = 1'b1;
        tick();
        tick();
        rst = 1'b1; req = 4'b1010;
        tick();
        #1;
        checks++; if (gnt_a !== 4'b0000) begin errors++; $display("FAIL rstmid_gnt: got %b want 0000", gnt_a); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", valid_a); end
        checks++; if (out_a !== 8'h00) begin errors++; $display("FAIL rstmid_out: got %h want 00", out_a); end
        rst = 1'b0;
        tick();
        #1;
        checks++; if (gnt_a !== 4'b0010) begin errors++; $display("FAIL rstmid_winner: got %b want 0010", gnt_a); end
    endtask

    task automatic test_burst1();
        logic [3:0] eg;
        logic [7:0] ed;
        do_reset();
        D0 = 8'h5A; D2 = 8'hC3; req = 4'b0101; ready = 1'b1;
        tick();
        for (int c = 0; c < 6; c++) begin
            eg = (c % 2 == 0) ? 4'b0001 : 4'b0100;
            ed = (c % 2 == 0) ? 8'h5A : 8'hC3;
            #1;
            checks++; if (gnt_b !== eg) begin errors++; $display("FAIL b1_gnt c%0d: got %b want %b", c, gnt_b, eg); end
            checks++; if (out_b !== ed) begin errors++; $display("FAIL b1_out c%0d: got %h want %h", c, out_b, ed); end
            tick();
        end
    endtask

    task automatic test_random();
        logic [3:0] g_obs [2];
        logic [7:0] o_obs [2];
        logic       v_obs [2];
        logic [1:0] s_obs [2];
        logic [3:0] eg;
        logic [7:0] ed;
        logic       ev;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            D0 = 8'($urandom); D1 = 8'($urandom); D2 = 8'($urandom); D3 = 8'($urandom);
            rst = ($urandom_range(0, 99) == 0);
            #1;
            g_obs[0] = gnt_a; o_obs[0] = out_a; v_obs[0] = valid_a; s_obs[0] = {s1_a, s0_a};
            g_obs[1] = gnt_b; o_obs[1] = out_b; v_obs[1] = valid_b; s_obs[1] = {s1_b, s0_b};
            for (int k = 0; k < 2; k++) begin
                eg = (m_busy[k] != 0) ? (4'b0001 << m_owner[k]) : 4'b0000;
                ev = (m_busy[k] != 0) && req[m_owner[k]];
                ed = (m_busy[k] != 0) ? word_of(m_owner[k]) : 8'h00;
                checks++; if (g_obs[k] !== eg) begin errors++; $display("FAIL rnd_gnt i%0d c%0d: got %b want %b", k, c, g_obs[k], eg); end
                checks++; if (v_obs[k] !== ev) begin errors++; $display("FAIL rnd_valid i%0d c%0d: got %b want %b", k, c, v_obs[k], ev); end
                checks++; if (o_obs[k] !== ed) begin errors++; $display("FAIL rnd_out i%0d c%0d: got %h want %h", k, c, o_obs[k], ed); end
                if (m_busy[k] != 0) begin
                    checks++; if (s_obs[k] !== 2'(m_owner[k])) begin errors++; $display("FAIL rnd_sel i%0d c%0d: got %b want %0d", k, c, s_obs[k], m_owner[k]); end
                end
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        m_max[0] = 4;
        m_max[1] = 1;
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_owner[k] = 0; m_last[k] = 3; m_done[k] = 0;
        end
        rst = 1'b1; req = 4'b0000; ready = 1'b0;
        D0 = 8'h00; D1 = 8'h00; D2 = 8'h00; D3 = 8'h00;
        @(negedge clk);
        test_reset();
        test_single();
        test_rotation();
        test_stall();
        test_drop();
        test_reset_mid();
        test_burst1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
